ysyx_25060173_bus_arbiter: RTL and testbench

YSYX_25060173_BUS_ARBITER -- requirements
Module: ysyx_25060173_bus_arbiter

---
 rtl/ysyx_25060173_bus_arbiter_pkg.sv | 22 ++
 rtl/ysyx_25060173_bus_arbiter_reg.sv | 18 +
 rtl/ysyx_25060173_bus_arbiter.sv | 117 +++++++++++
 tb/tb_ysyx_25060173_bus_arbiter.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_25060173_bus_arbiter_pkg.sv
// Shared definitions for the two-master shared-memory bus arbiter.
// Holds the FSM state encodings, the master ids and the grant-selection helper.
package ysyx_25060173_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } arb_state_t;

  localparam logic MASTER_IFU = 1'b0;
  localparam logic MASTER_LSU = 1'b1;

  // On contention the master that was not granted last time wins.
  function automatic logic pick_master(input logic m0_valid, input logic m1_valid,
                                       input logic last_grant);
    if (m0_valid && m1_valid) return ~last_grant;
    else if (m1_valid)        return MASTER_LSU;
    else                      return MASTER_IFU;
  endfunction

endpackage

// File: rtl/ysyx_25060173_bus_arbiter_reg.sv
// Team register template: load-enabled register, asynchronous active-low reset.
module ysyx_25060173_Reg #(
  parameter int                WIDTH     = 1,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             wen,
  output logic [WIDTH-1:0] dout
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)     dout <= RESET_VAL;
    else if (wen) dout <= din;
  end

endmodule

// File: rtl/ysyx_25060173_bus_arbiter.sv
// Round-robin arbiter letting the IFU (m0) and LSU (m1) share one memory slave,
// with exactly one transaction in flight at a time.
module ysyx_25060173_bus_arbiter
  import ysyx_25060173_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                m0_req_valid,
  output logic                m0_req_ready,
  input  logic [ADDR_W-1:0]   m0_addr,
  input  logic                m0_wen,
  input  logic [DATA_W-1:0]   m0_wdata,
  input  logic [DATA_W/8-1:0] m0_wmask,
  output logic                m0_rsp_valid,
  input  logic                m0_rsp_ready,
  output logic [DATA_W-1:0]   m0_rdata,
  input  logic                m1_req_valid,
  output logic                m1_req_ready,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic                m1_wen,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic [DATA_W/8-1:0] m1_wmask,
  output logic                m1_rsp_valid,
  input  logic                m1_rsp_ready,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic                s_req_valid,
  input  logic                s_req_ready,
  output logic [ADDR_W-1:0]   s_addr,
  output logic                s_wen,
  output logic [DATA_W-1:0]   s_wdata,
  output logic [DATA_W/8-1:0] s_wmask,
  input  logic                s_rsp_valid,
  output logic                s_rsp_ready,
  input  logic [DATA_W-1:0]   s_rdata
);

  localparam int MASK_W = DATA_W / 8;
  localparam int PAY_W  = ADDR_W + 1 + DATA_W + MASK_W;

  arb_state_t         r_state;
  arb_state_t         w_next;
  logic               w_grant;
  logic               w_grant_id;
  logic               w_rsp_ready;
  logic [PAY_W-1:0]   w_pay_in;
  logic [PAY_W-1:0]   r_pay;
  logic               r_owner;
  logic               r_last;

  assign w_grant_id = pick_master(m0_req_valid, m1_req_valid, r_last);
  assign w_pay_in   = (w_grant_id == MASTER_LSU) ? {m1_addr, m1_wen, m1_wdata, m1_wmask}
                                                 : {m0_addr, m0_wen, m0_wdata, m0_wmask};
  assign {s_addr, s_wen, s_wdata, s_wmask} = r_pay;

  ysyx_25060173_Reg #(.WIDTH(PAY_W), .RESET_VAL('0)) u_payload (
    .clk(clk), .rst(rst), .din(w_pay_in), .wen(w_grant), .dout(r_pay)
  );

  ysyx_25060173_Reg #(.WIDTH(1), .RESET_VAL(MASTER_IFU)) u_owner (
    .clk(clk), .rst(rst), .din(w_grant_id), .wen(w_grant), .dout(r_owner)
  );

  // Reset value "last = LSU" makes the IFU win the first contention.
  ysyx_25060173_Reg #(.WIDTH(1), .RESET_VAL(MASTER_LSU)) u_last (
    .clk(clk), .rst(rst), .din(w_grant_id), .wen(w_grant), .dout(r_last)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_next;
  end

  // Grant is qualified with rst so no ready escapes while reset is held.
  always_comb begin
    w_next       = r_state;
    w_grant      = 1'b0;
    w_rsp_ready  = 1'b0;
    s_req_valid  = 1'b0;
    m0_rsp_valid = 1'b0;
    m1_rsp_valid = 1'b0;
    m0_rdata     = '0;
    m1_rdata     = '0;
    case (r_state)
      ST_IDLE: begin
        if (rst && (m0_req_valid || m1_req_valid)) begin
          w_grant = 1'b1;
          w_next  = ST_REQ;
        end
      end
      ST_REQ: begin
        s_req_valid = 1'b1;
        if (s_req_ready) w_next = ST_RESP;
      end
      ST_RESP: begin
        if (r_owner == MASTER_LSU) begin
          m1_rsp_valid = s_rsp_valid;
          m1_rdata     = s_rdata;
          w_rsp_ready  = m1_rsp_ready;
        end else begin
          m0_rsp_valid = s_rsp_valid;
          m0_rdata     = s_rdata;
          w_rsp_ready  = m0_rsp_ready;
        end
        if (s_rsp_valid && w_rsp_ready) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  assign s_rsp_ready  = w_rsp_ready;
  assign m0_req_ready = w_grant && (w_grant_id == MASTER_IFU);
  assign m1_req_ready = w_grant && (w_grant_id == MASTER_LSU);

endmodule

// File: tb/tb_ysyx_25060173_bus_arbiter.sv
// Directed bench for the bus arbiter: a table of single transactions followed by
// hand-written sequences for round-robin, slave stalls, response back-pressure and reset.
module tb_ysyx_25060173_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        m0_req_valid = 1'b0, m1_req_valid = 1'b0;
  logic        m0_req_ready, m1_req_ready;
  logic [31:0] m0_addr = '0, m1_addr = '0;
  logic        m0_wen = 1'b0, m1_wen = 1'b0;
  logic [31:0] m0_wdata = '0, m1_wdata = '0;
  logic [3:0]  m0_wmask = '0, m1_wmask = '0;
  logic        m0_rsp_valid, m1_rsp_valid;
  logic        m0_rsp_ready = 1'b0, m1_rsp_ready = 1'b0;
  logic [31:0] m0_rdata, m1_rdata;
  logic        s_req_valid;
  logic        s_req_ready = 1'b0;
  logic [31:0] s_addr;
  logic        s_wen;
  logic [31:0] s_wdata;
  logic [3:0]  s_wmask;
  logic        s_rsp_valid = 1'b0;
  logic        s_rsp_ready;
  logic [31:0] s_rdata = '0;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ysyx_25060173_bus_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready), .m0_addr(m0_addr),
    .m0_wen(m0_wen), .m0_wdata(m0_wdata), .m0_wmask(m0_wmask),
    .m0_rsp_valid(m0_rsp_valid), .m0_rsp_ready(m0_rsp_ready), .m0_rdata(m0_rdata),
    .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready), .m1_addr(m1_addr),
    .m1_wen(m1_wen), .m1_wdata(m1_wdata), .m1_wmask(m1_wmask),
    .m1_rsp_valid(m1_rsp_valid), .m1_rsp_ready(m1_rsp_ready), .m1_rdata(m1_rdata),
    .s_req_valid(s_req_valid), .s_req_ready(s_req_ready), .s_addr(s_addr),
    .s_wen(s_wen), .s_wdata(s_wdata), .s_wmask(s_wmask),
    .s_rsp_valid(s_rsp_valid), .s_rsp_ready(s_rsp_ready), .s_rdata(s_rdata)
  );

  typedef struct packed {
    logic        m0v;
    logic        m1v;
    logic [31:0] a0;
    logic [31:0] a1;
    logic        w0;
    logic        w1;
    logic [31:0] d0;
    logic [31:0] d1;
    logic [3:0]  k0;
    logic [3:0]  k1;
    logic [31:0] rdata;
    logic        expOwner;
  } vec_t;

  vec_t vecs [8];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // One full transaction: grant cycle, request cycle, response cycle, back to idle.
  task automatic applyStimulus(input vec_t v, input int idx);
    logic [31:0] eAddr, eData;
    logic        eWen;
    logic [3:0]  eMask;
    eAddr = v.expOwner ? v.a1 : v.a0;
    eData = v.expOwner ? v.d1 : v.d0;
    eWen  = v.expOwner ? v.w1 : v.w0;
    eMask = v.expOwner ? v.k1 : v.k0;
    @(negedge clk);
    m0_req_valid = v.m0v; m1_req_valid = v.m1v;
    m0_addr = v.a0; m1_addr = v.a1; m0_wen = v.w0; m1_wen = v.w1;
    m0_wdata = v.d0; m1_wdata = v.d1; m0_wmask = v.k0; m1_wmask = v.k1;
    s_req_ready = 1'b0; s_rsp_valid = 1'b0; m0_rsp_ready = 1'b0; m1_rsp_ready = 1'b0;
    #1;
    checkOutput($sformatf("v%0d_m0_req_ready", idx), m0_req_ready, !v.expOwner);
    checkOutput($sformatf("v%0d_m1_req_ready", idx), m1_req_ready, v.expOwner);
    checkOutput($sformatf("v%0d_idle_s_req_valid", idx), s_req_valid, 0);
    @(negedge clk);
    m0_req_valid = 1'b0; m1_req_valid = 1'b0; s_req_ready = 1'b1;
    #1;
    checkOutput($sformatf("v%0d_s_req_valid", idx), s_req_valid, 1);
    checkOutput($sformatf("v%0d_s_addr", idx), s_addr, eAddr);
    checkOutput($sformatf("v%0d_s_wen", idx), s_wen, eWen);
    checkOutput($sformatf("v%0d_s_wdata", idx), s_wdata, eData);
    checkOutput($sformatf("v%0d_s_wmask", idx), s_wmask, eMask);
    checkOutput($sformatf("v%0d_req_ready_in_req", idx), {m0_req_ready, m1_req_ready}, 0);
    @(negedge clk);
    s_req_ready = 1'b0; s_rsp_valid = 1'b1; s_rdata = v.rdata;
    m0_rsp_ready = 1'b1; m1_rsp_ready = 1'b1;
    #1;
    checkOutput($sformatf("v%0d_m0_rsp_valid", idx), m0_rsp_valid, !v.expOwner);
    checkOutput($sformatf("v%0d_m1_rsp_valid", idx), m1_rsp_valid, v.expOwner);
    checkOutput($sformatf("v%0d_m0_rdata", idx), m0_rdata, v.expOwner ? 32'h0 : v.rdata);
    checkOutput($sformatf("v%0d_m1_rdata", idx), m1_rdata, v.expOwner ? v.rdata : 32'h0);
    checkOutput($sformatf("v%0d_s_rsp_ready", idx), s_rsp_ready, 1);
    checkOutput($sformatf("v%0d_resp_s_req_valid", idx), s_req_valid, 0);
    @(negedge clk);
    s_rsp_valid = 1'b0; m0_rsp_ready = 1'b0; m1_rsp_ready = 1'b0;
    #1;
    checkOutput($sformatf("v%0d_idle_s_rsp_ready", idx), s_rsp_ready, 0);
  endtask

  initial begin
    int   nGrants;
    logic dualSeen;
    logic grantIds [4];

    //            m0v  m1v  a0            a1            w0   w1   d0            d1            k0       k1       rdata         owner
    vecs[0] = '{1'b1, 1'b0, 32'h8000_0000, 32'h0,        1'b0, 1'b0, 32'h0,        32'h0,        4'h0,    4'h0,    32'h1234_5678, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 32'h8000_0100, 32'h8000_0200, 1'b0, 1'b1, 32'h0,        32'hCAFE_0001, 4'h0,    4'b1111, 32'h0000_0001, 1'b1};
    vecs[2] = '{1'b1, 1'b1, 32'h8000_0104, 32'h8000_0204, 1'b0, 1'b0, 32'h0,        32'h0,        4'h0,    4'h0,    32'h0000_0002, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 32'h0,        32'h8000_0300, 1'b0, 1'b1, 32'h0,        32'h5555_AAAA, 4'h0,    4'b0101, 32'hFFFF_FFFF, 1'b1};
    vecs[4] = '{1'b0, 1'b1, 32'h0,        32'h8000_0304, 1'b0, 1'b0, 32'h0,        32'h0,        4'h0,    4'h0,    32'h8765_4321, 1'b1};
    vecs[5] = '{1'b1, 1'b1, 32'h8000_0108, 32'h8000_0308, 1'b1, 1'b1, 32'h1111_2222, 32'h3333_4444, 4'b1000, 4'b0001, 32'h0BAD_F00D, 1'b0};
    vecs[6] = '{1'b1, 1'b0, 32'h8000_010C, 32'h0,        1'b0, 1'b0, 32'h0,        32'h0,        4'h0,    4'h0,    32'h0000_00A5, 1'b0};
    vecs[7] = '{1'b1, 1'b1, 32'h8000_0110, 32'h8000_0310, 1'b0, 1'b1, 32'h0,        32'h7777_8888, 4'h0,    4'b1100, 32'h0000_0003, 1'b1};

    // Reset state, with a request pending that must not be acknowledged yet.
    m0_req_valid = 1'b1;
    #12;
    checkOutput("rst_m0_req_ready", m0_req_ready, 0);
    checkOutput("rst_s_req_valid", s_req_valid, 0);
    checkOutput("rst_s_rsp_ready", s_rsp_ready, 0);
    checkOutput("rst_rsp_valid", {m0_rsp_valid, m1_rsp_valid}, 0);
    checkOutput("rst_s_addr", s_addr, 0);
    m0_req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 8; i++) applyStimulus(vecs[i], i);

    // Both masters requesting back to back from reset: grants must alternate.
    @(negedge clk);
    rst = 1'b0;
    m0_req_valid = 1'b1; m1_req_valid = 1'b1;
    m0_addr = 32'h1000_0000; m1_addr = 32'h2000_0000; m0_wen = 1'b0; m1_wen = 1'b0;
    s_req_ready = 1'b1; s_rsp_valid = 1'b1; s_rdata = 32'h0000_0042;
    m0_rsp_ready = 1'b1; m1_rsp_ready = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    nGrants = 0;
    dualSeen = 1'b0;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (m0_req_ready && m1_req_ready) dualSeen = 1'b1;
      if (m0_req_ready || m1_req_ready) begin
        if (nGrants < 4) grantIds[nGrants] = m1_req_ready;
        nGrants++;
        checkOutput($sformatf("rr_idle_rsp_valid_%0d", c), {m0_rsp_valid, m1_rsp_valid}, 0);
      end
      @(negedge clk);
    end
    checkOutput("rr_grant_count", nGrants, 4);
    checkOutput("rr_no_dual_grant", dualSeen, 0);
    for (int k = 0; k < 4; k++)
      if (k < nGrants) checkOutput($sformatf("rr_grant_%0d", k), grantIds[k], k % 2);
    m0_req_valid = 1'b0; m1_req_valid = 1'b0;
    repeat (3) @(negedge clk);
    s_req_ready = 1'b0; s_rsp_valid = 1'b0; m0_rsp_ready = 1'b0; m1_rsp_ready = 1'b0;

    // LSU write with the slave stalling for five cycles.
    m1_req_valid = 1'b1; m1_addr = 32'h8000_0010; m1_wen = 1'b1;
    m1_wdata = 32'hDEAD_BEEF; m1_wmask = 4'b0011;
    #1;
    checkOutput("stall_m1_grant", m1_req_ready, 1);
    checkOutput("stall_m0_no_grant", m0_req_ready, 0);
    @(negedge clk);
    m0_req_valid = 1'b1; m0_addr = 32'h3000_0000; m0_wen = 1'b0;
    m1_addr = 32'h0; m1_wdata = 32'h0; m1_wmask = 4'h0;
    for (int c = 0; c < 5; c++) begin
      #1;
      checkOutput($sformatf("stall_s_req_valid_%0d", c), s_req_valid, 1);
      checkOutput($sformatf("stall_s_addr_%0d", c), s_addr, 32'h8000_0010);
      checkOutput($sformatf("stall_s_wdata_%0d", c), s_wdata, 32'hDEAD_BEEF);
      checkOutput($sformatf("stall_s_wmask_%0d", c), s_wmask, 4'b0011);
      checkOutput($sformatf("stall_s_wen_%0d", c), s_wen, 1);
      checkOutput($sformatf("stall_req_ready_%0d", c), {m0_req_ready, m1_req_ready}, 0);
      @(negedge clk);
    end
    m1_req_valid = 1'b0; s_req_ready = 1'b1;
    @(negedge clk);

    // Response offered but the owner holds off for three cycles.
    s_req_ready = 1'b0; s_rsp_valid = 1'b1; s_rdata = 32'hA5A5_0001; m1_rsp_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      checkOutput($sformatf("hold_m1_rsp_valid_%0d", c), m1_rsp_valid, 1);
      checkOutput($sformatf("hold_s_rsp_ready_%0d", c), s_rsp_ready, 0);
      checkOutput($sformatf("hold_m0_req_ready_%0d", c), m0_req_ready, 0);
      checkOutput($sformatf("hold_m0_rsp_valid_%0d", c), m0_rsp_valid, 0);
      @(negedge clk);
    end
    m1_rsp_ready = 1'b1;
    #1;
    checkOutput("hold_release_s_rsp_ready", s_rsp_ready, 1);
    checkOutput("hold_release_m1_rdata", m1_rdata, 32'hA5A5_0001);
    @(negedge clk);
    s_rsp_valid = 1'b0; m1_rsp_ready = 1'b0;
    #1;
    checkOutput("post_hold_m0_grant", m0_req_ready, 1);
    checkOutput("post_hold_m1_no_grant", m1_req_ready, 0);
    @(negedge clk);
    #1;
    checkOutput("prerst_s_req_valid", s_req_valid, 1);
    checkOutput("prerst_s_addr", s_addr, 32'h3000_0000);

    // Reset in the middle of the request phase with both masters pending.
    m1_req_valid = 1'b1; m1_addr = 32'h9000_0040; m1_wen = 1'b0;
    s_rsp_valid = 1'b1; m0_rsp_ready = 1'b1; m1_rsp_ready = 1'b1;
    rst = 1'b0;
    #1;
    checkOutput("midrst_s_req_valid", s_req_valid, 0);
    checkOutput("midrst_req_ready", {m0_req_ready, m1_req_ready}, 0);
    checkOutput("midrst_rsp_valid", {m0_rsp_valid, m1_rsp_valid}, 0);
    checkOutput("midrst_s_rsp_ready", s_rsp_ready, 0);
    checkOutput("midrst_s_addr", s_addr, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("postrst_m0_grant", m0_req_ready, 1);
    checkOutput("postrst_m1_no_grant", m1_req_ready, 0);
    checkOutput("postrst_rsp_valid", {m0_rsp_valid, m1_rsp_valid}, 0);
    checkOutput("postrst_s_req_valid", s_req_valid, 0);
    @(negedge clk);
    m0_req_valid = 1'b0; s_req_ready = 1'b1;
    #1;
    checkOutput("postrst_s_addr_m0", s_addr, 32'h3000_0000);
    @(negedge clk);
    #1;
    checkOutput("postrst_m0_rsp_valid", m0_rsp_valid, 1);
    checkOutput("postrst_m1_rsp_valid", m1_rsp_valid, 0);
    @(negedge clk);
    #1;
    checkOutput("postrst_m1_regrant", m1_req_ready, 1);
    checkOutput("postrst_m0_no_grant", m0_req_ready, 0);
    @(negedge clk);
    m1_req_valid = 1'b0;
    #1;
    checkOutput("postrst_s_addr_m1", s_addr, 32'h9000_0040);
    checkOutput("postrst_s_wen_m1", s_wen, 0);
    repeat (3) @(negedge clk);
    s_req_ready = 1'b0; s_rsp_valid = 1'b0; m0_rsp_ready = 1'b0; m1_rsp_ready = 1'b0;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
